// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: FSM state encodings, opcode patterns and
// datapath select encodings used by the multi-cycle control unit.
package legv8_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_WB_R      = 4'd3,
        ST_MEM_ADDR  = 4'd4,
        ST_MEM_RD    = 4'd5,
        ST_WB_MEM    = 4'd6,
        ST_MEM_WR    = 4'd7,
        ST_BR_COND   = 4'd8,
        ST_BR_UNCOND = 4'd9
    } state_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CBZ and B carry part of their immediate inside bits [31:21].
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] MASK_CBZ = 11'b11111111000;
    localparam logic [10:0] OP_B     = 11'b00010100000;
    localparam logic [10:0] MASK_B   = 11'b11111100000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] ASB_REGB  = 2'b00;
    localparam logic [1:0] ASB_FOUR  = 2'b01;
    localparam logic [1:0] ASB_ADDR  = 2'b10;
    localparam logic [1:0] ASB_BROFF = 2'b11;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] pattern,
                                      input logic [10:0] mask);
        return ((op ^ pattern) & mask) == 11'd0;
    endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational classifier of IR bits [31:21] into the instruction groups the
// control FSM branches on.
module legv8_opcode_class
    import legv8_pkg::*;
(
    input  logic [10:0] opcode,
    output logic        is_rtype,
    output logic        is_ldur,
    output logic        is_stur,
    output logic        is_cbz,
    output logic        is_b,
    output logic        is_illegal
);

    assign is_rtype   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                        (opcode == OP_AND) || (opcode == OP_ORR);
    assign is_ldur    = (opcode == OP_LDUR);
    assign is_stur    = (opcode == OP_STUR);
    assign is_cbz     = op_match(opcode, OP_CBZ, MASK_CBZ);
    assign is_b       = op_match(opcode, OP_B, MASK_B);
    assign is_illegal = !(is_rtype || is_ldur || is_stur || is_cbz || is_b);

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 main control: Moore FSM driving datapath enables/selects.
// Define MEM_WAIT_EN to add the mem_ready handshake on FETCH, MEM_RD, MEM_WR.
module legv8_multicycle_control
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode,
    input  logic        zero,
`ifdef MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_src,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        reg2_loc,
    output logic        illegal_op,
    output logic [3:0]  state
);

    localparam logic [3:0] FETCH     = ST_FETCH;
    localparam logic [3:0] DECODE    = ST_DECODE;
    localparam logic [3:0] EXEC_R    = ST_EXEC_R;
    localparam logic [3:0] WB_R      = ST_WB_R;
    localparam logic [3:0] MEM_ADDR  = ST_MEM_ADDR;
    localparam logic [3:0] MEM_RD    = ST_MEM_RD;
    localparam logic [3:0] WB_MEM    = ST_WB_MEM;
    localparam logic [3:0] MEM_WR    = ST_MEM_WR;
    localparam logic [3:0] BR_COND   = ST_BR_COND;
    localparam logic [3:0] BR_UNCOND = ST_BR_UNCOND;

    logic [3:0] cur_state;
    logic [3:0] next_state;
    logic       mem_done;
    logic       is_rtype, is_ldur, is_stur, is_cbz, is_b, is_illegal;

    // The branch decision itself happens in the PC logic (pc_write_cond & zero).
    logic       zero_unused;
    assign zero_unused = zero;

`ifdef MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    legv8_opcode_class u_class (
        .opcode     (opcode),
        .is_rtype   (is_rtype),
        .is_ldur    (is_ldur),
        .is_stur    (is_stur),
        .is_cbz     (is_cbz),
        .is_b       (is_b),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= FETCH;
        else     cur_state <= next_state;
    end

    assign state = cur_state;

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            FETCH:     next_state = mem_done ? DECODE : FETCH;
            DECODE: begin
                if (is_rtype)                next_state = EXEC_R;
                else if (is_ldur || is_stur) next_state = MEM_ADDR;
                else if (is_cbz)             next_state = BR_COND;
                else if (is_b)               next_state = BR_UNCOND;
                else                         next_state = FETCH;
            end
            EXEC_R:    next_state = WB_R;
            WB_R:      next_state = FETCH;
            MEM_ADDR: begin
                if (is_ldur)      next_state = MEM_RD;
                else if (is_stur) next_state = MEM_WR;
                else              next_state = FETCH;
            end
            MEM_RD:    next_state = mem_done ? WB_MEM : MEM_RD;
            WB_MEM:    next_state = FETCH;
            MEM_WR:    next_state = mem_done ? FETCH : MEM_WR;
            BR_COND:   next_state = FETCH;
            BR_UNCOND: next_state = FETCH;
            default:   next_state = FETCH;
        endcase
    end

    // Outputs are forced low while rst is high so an aborted write never lands.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = ASB_REGB;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg2_loc      = 1'b0;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (cur_state)
                FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_done;
                    pc_write  = mem_done;
                    alu_src_b = ASB_FOUR;
                end
                DECODE: begin
                    alu_src_b  = ASB_BROFF;
                    reg2_loc   = is_stur || is_cbz;
                    illegal_op = is_illegal;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_RTYPE;
                end
                WB_R:      reg_write = 1'b1;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_ADDR;
                    reg2_loc  = is_stur;
                end
                MEM_RD:    mem_read = 1'b1;
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    reg2_loc  = 1'b1;
                end
                BR_COND: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_PASSB;
                    reg2_loc      = 1'b1;
                    pc_write_cond = 1'b1;
                    pc_src        = 1'b1;
                end
                BR_UNCOND: begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed table-driven bench for legv8_multicycle_control; MEM_WAIT_EN adds
// the wait-state sequences.
module tb_legv8_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] opcode = 11'b10001011000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        ir_write, pc_write, pc_write_cond, pc_src;
    logic [1:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mem_read, mem_write, mem_to_reg, reg_write, reg2_loc, illegal_op;
    logic [3:0]  state;

    legv8_multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
`ifdef MEM_WAIT_EN
        .mem_ready     (mem_ready),
`endif
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .reg2_loc      (reg2_loc),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    // {ir_write, pc_write, pc_write_cond, pc_src, alu_op, alu_src_a, alu_src_b,
    //  mem_read, mem_write, mem_to_reg, reg_write, reg2_loc, illegal_op}
    logic [14:0] act;
    assign act = {ir_write, pc_write, pc_write_cond, pc_src, alu_op, alu_src_a,
                  alu_src_b, mem_read, mem_write, mem_to_reg, reg_write,
                  reg2_loc, illegal_op};

    localparam logic [14:0] O_ZERO      = 15'b0000_00_0_00_0000_00;
    localparam logic [14:0] O_FETCH     = 15'b1100_00_0_01_1000_00;
    localparam logic [14:0] O_FETCH_W   = 15'b0000_00_0_01_1000_00;
    localparam logic [14:0] O_DEC       = 15'b0000_00_0_11_0000_00;
    localparam logic [14:0] O_DEC_R2    = 15'b0000_00_0_11_0000_10;
    localparam logic [14:0] O_DEC_ILL   = 15'b0000_00_0_11_0000_01;
    localparam logic [14:0] O_EXEC_R    = 15'b0000_10_1_00_0000_00;
    localparam logic [14:0] O_WB_R      = 15'b0000_00_0_00_0001_00;
    localparam logic [14:0] O_MADDR     = 15'b0000_00_1_10_0000_00;
    localparam logic [14:0] O_MADDR_R2  = 15'b0000_00_1_10_0000_10;
    localparam logic [14:0] O_MEM_RD    = 15'b0000_00_0_00_1000_00;
    localparam logic [14:0] O_WB_MEM    = 15'b0000_00_0_00_0011_00;
    localparam logic [14:0] O_MEM_WR    = 15'b0000_00_0_00_0100_10;
    localparam logic [14:0] O_BR_COND   = 15'b0011_01_1_00_0000_10;
    localparam logic [14:0] O_BR_UNCOND = 15'b0101_00_0_00_0000_00;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDI = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] BR   = 11'b00010111111;
    localparam logic [10:0] ILL0 = 11'b00000000000;
    localparam logic [10:0] ILL1 = 11'b11111000011;

    typedef struct {
        logic        rst;
        logic [10:0] opcode;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] outs;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   failed = 0;

    task automatic v(input logic r, input logic [10:0] op, input logic z,
                     input logic [3:0] st, input logic [14:0] o);
        vec_t e;
        e.rst = r; e.opcode = op; e.zero = z; e.st = st; e.outs = o;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        repeat (3) v(1, ADD, 0, 4'd0, O_ZERO);
        // ADD
        v(0, ADD, 0, 4'd0, O_FETCH);   v(0, ADD, 0, 4'd1, O_DEC);
        v(0, ADD, 0, 4'd2, O_EXEC_R);  v(0, ADD, 0, 4'd3, O_WB_R);
        // LDUR
        v(0, LDUR, 0, 4'd0, O_FETCH);  v(0, LDUR, 0, 4'd1, O_DEC);
        v(0, LDUR, 0, 4'd4, O_MADDR);  v(0, LDUR, 0, 4'd5, O_MEM_RD);
        v(0, LDUR, 0, 4'd6, O_WB_MEM);
        // STUR
        v(0, STUR, 0, 4'd0, O_FETCH);  v(0, STUR, 0, 4'd1, O_DEC_R2);
        v(0, STUR, 0, 4'd4, O_MADDR_R2); v(0, STUR, 0, 4'd7, O_MEM_WR);
        // CBZ taken and not taken
        v(0, CBZ, 1, 4'd0, O_FETCH);   v(0, CBZ, 1, 4'd1, O_DEC_R2);
        v(0, CBZ, 1, 4'd8, O_BR_COND);
        v(0, CBZ, 0, 4'd0, O_FETCH);   v(0, CBZ, 0, 4'd1, O_DEC_R2);
        v(0, CBZ, 0, 4'd8, O_BR_COND);
        // B
        v(0, BR, 0, 4'd0, O_FETCH);    v(0, BR, 0, 4'd1, O_DEC);
        v(0, BR, 0, 4'd9, O_BR_UNCOND);
        // illegal opcodes, each followed by a legal R-type
        v(0, ILL0, 0, 4'd0, O_FETCH);  v(0, ILL0, 0, 4'd1, O_DEC_ILL);
        v(0, ORR, 0, 4'd0, O_FETCH);   v(0, ORR, 0, 4'd1, O_DEC);
        v(0, ORR, 0, 4'd2, O_EXEC_R);  v(0, ORR, 0, 4'd3, O_WB_R);
        v(0, ILL1, 0, 4'd0, O_FETCH);  v(0, ILL1, 0, 4'd1, O_DEC_ILL);
        v(0, SUB, 0, 4'd0, O_FETCH);   v(0, SUB, 0, 4'd1, O_DEC);
        v(0, SUB, 0, 4'd2, O_EXEC_R);  v(0, SUB, 0, 4'd3, O_WB_R);
        v(0, ANDI, 0, 4'd0, O_FETCH);  v(0, ANDI, 0, 4'd1, O_DEC);
        v(0, ANDI, 0, 4'd2, O_EXEC_R); v(0, ANDI, 0, 4'd3, O_WB_R);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; opcode = tbl[i].opcode; zero = tbl[i].zero;
            #1;
            chk($sformatf("row%0d_state", i), {11'd0, state}, {11'd0, tbl[i].st});
            chk($sformatf("row%0d_outs", i), act, tbl[i].outs);
        end

        // Reset asserted in WB_MEM aborts the write-back at once.
        @(negedge clk); opcode = LDUR; #1;
        chk("rstwb_fetch", {11'd0, state}, 15'd0);
        repeat (4) @(negedge clk);
        #1;
        chk("rstwb_in_wbmem", {11'd0, state}, 15'd6);
        chk("rstwb_regwrite_before", {14'd0, reg_write}, 15'd1);
        rst = 1'b1; #1;
        chk("rstwb_regwrite_after", {14'd0, reg_write}, 15'd0);
        chk("rstwb_outs_zero", act, O_ZERO);
        chk("rstwb_state_zero", {11'd0, state}, 15'd0);
        @(negedge clk); rst = 1'b0; opcode = ADD; #1;
        chk("rstwb_first_fetch", act, O_FETCH);
        @(negedge clk); #1;
        chk("rstwb_then_decode", {11'd0, state}, 15'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("rstwb_back_fetch", {11'd0, state}, 15'd0);

`ifdef MEM_WAIT_EN
        // FETCH stalls without ir_write/pc_write until mem_ready.
        mem_ready = 1'b0; opcode = STUR; #1;
        chk("wait_fetch_stall", act, O_FETCH_W);
        @(negedge clk); #1;
        chk("wait_fetch_hold", {11'd0, state}, 15'd0);
        mem_ready = 1'b1; #1;
        chk("wait_fetch_ready", act, O_FETCH);
        @(negedge clk); #1;
        chk("wait_decode", act, O_DEC_R2);
        @(negedge clk); #1;
        chk("wait_maddr", act, O_MADDR_R2);
        @(negedge clk); mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wait_memwr%0d_state", i), {11'd0, state}, 15'd7);
            chk($sformatf("wait_memwr%0d_outs", i), act, O_MEM_WR);
            @(negedge clk); #1;
        end
        mem_ready = 1'b1; #1;
        chk("wait_memwr3_outs", act, O_MEM_WR);
        @(negedge clk); #1;
        chk("wait_after_fetch", {11'd0, state}, 15'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_control.md
# legv8_multicycle_control

Multi-cycle main control unit for the LEGv8 datapath. A Moore state machine steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, including the 2-bit `alu_op` field that the ALU control decoder turns into the 4-bit ALU function. It sits between the instruction register (source of `opcode`) and the datapath, and is the sole producer of `alu_op`.

## Interface
Parameters:
- none; state encodings and opcode constants live in the shared package.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  11  instruction bits [31:21], taken from the IR; stable from DECODE onward.
- `zero`  in  1  ALU zero flag; used by CBZ only.
- `mem_ready`  in  1  memory access complete; present only with `MEM_WAIT_EN`.
- `ir_write`  out  1  load the IR.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load when `zero` is 1.
- `pc_src`  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- `alu_op`  out  2  00 = add, 01 = pass B / compare with zero, 10 = R-type (function taken from `opcode`).
- `alu_src_a`  out  1  ALU input A: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU input B: 00 = register B, 01 = constant 4, 10 = sign-extended address, 11 = branch offset << 2.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `mem_to_reg`  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- `reg_write`  out  1  register file write enable.
- `reg2_loc`  out  1  second read register comes from Rt (bits [4:0]).
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unrecognised opcode.
- `state`  out  4  current state, for debug.

## Operation
Opcodes recognised:
- R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
- LDUR 11111000010, STUR 11111000000.
- CBZ: `opcode[10:3]` = 10110100.
- B: `opcode[10:5]` = 000101.

States and the outputs asserted in each (all unlisted outputs are 0):
- FETCH: `mem_read`, `ir_write`, `pc_write`, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=0. Next state is DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut); `reg2_loc`=1 for STUR or CBZ.
  - Next state: R-type → EXEC_R; LDUR or STUR → MEM_ADDR; CBZ → BR_COND; B → BR_UNCOND.
  - Any other opcode: raise `illegal_op` and go to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state is WB_R.
- WB_R: `reg_write`, `mem_to_reg`=0. Next state is FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, `reg2_loc` held at 1 for STUR. Next state: LDUR → MEM_RD; STUR → MEM_WR.
- MEM_RD: `mem_read`. Next state is WB_MEM.
- WB_MEM: `reg_write`, `mem_to_reg`=1. Next state is FETCH.
- MEM_WR: `mem_write`, `reg2_loc`=1. Next state is FETCH.
- BR_COND: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `reg2_loc`=1, `pc_write_cond`, `pc_src`=1. Next state is FETCH.
- BR_UNCOND: `pc_write`, `pc_src`=1. Next state is FETCH.

## Timing
- Outputs are pure Moore decode of the state register. `illegal_op` and `reg2_loc` additionally decode `opcode` within their state.
- Reset:
  - While `rst` is high, the state is FETCH and every output is 0, including `state`, which reads the FETCH encoding 0.
  - The first fetch takes place in the first clock after `rst` falls.
  - `rst` asserted mid-instruction aborts it immediately; no register or memory write occurs after the reset edge.
- Cycles per instruction, with no wait states: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3, illegal 2.
- CBZ: the PC updates at the end of BR_COND only if `zero` is 1 in that cycle.

## Configuration
`MEM_WAIT_EN`:
- Defined:
  - The `mem_ready` port exists.
  - FETCH, MEM_RD and MEM_WR hold their state until `mem_ready` is 1, with `mem_read`/`mem_write` held high throughout.
  - In FETCH, `ir_write` and `pc_write` assert only in the cycle where `mem_ready` is 1.
  - If `mem_ready` is 1 on entry, no extra cycle is added.
- Undefined: there is no `mem_ready` port, and every memory state lasts exactly one cycle.

## Structure
- Shared package `legv8_pkg`:
  - state enum (4-bit, FETCH = 0);
  - opcode constants and masks for CBZ and B;
  - `alu_op` encodings (ALU_ADD = 00, ALU_PASSB = 01, ALU_RTYPE = 10);
  - `alu_src_b` encodings.
- One sub-module, `legv8_opcode_class`: combinational opcode classifier with outputs `is_rtype`, `is_ldur`, `is_stur`, `is_cbz`, `is_b`, `is_illegal`. The FSM uses these flags in DECODE and MEM_ADDR.

## Test plan
- Reset held 3 cycles, then released with `opcode`=ADD → all outputs 0 during reset; sequence FETCH, DECODE, EXEC_R (`alu_op`=10), WB_R (`reg_write`=1), FETCH over 4 cycles.
- LDUR 11111000010 → MEM_ADDR with `alu_src_b`=10 and `alu_op`=00, then MEM_RD, then WB_MEM with `mem_to_reg`=1; 5 cycles total.
- CBZ 10110100xxx with `zero`=1, then again with `zero`=0 → BR_COND shows `alu_op`=01 and `pc_write_cond`=1 in both runs; FETCH follows after 3 cycles in both.
- Opcode 00000000000 → `illegal_op` high for exactly one cycle in DECODE, then FETCH; no `reg_write` or `mem_write` asserted.
- `MEM_WAIT_EN` defined, STUR with `mem_ready` low for 3 cycles in MEM_WR → `mem_write` held for 4 cycles; FETCH reached the cycle after `mem_ready` goes high.
- `rst` asserted during WB_MEM → `reg_write` drops to 0 immediately; after release, the first state is FETCH.
